// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- memory-access stage of a five-stage in-order pipeline.
//
// Accepts one instruction from EX, waits for the data-SRAM response owed by a
// load or store, extends load data, and hands the result to WB. A cancel
// counter tracks SRAM responses that are still in flight for instructions
// killed by an exception flush, so that those late responses are discarded
// and never mistaken for the data of a younger instruction.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   es_to_ms_valid / ms_allowin  EX->MEM handshake
//   es_pc, es_result           PC and ALU result / load address
//   es_rf_we, es_rf_waddr      register write enable and destination
//   es_res_from_mem            instruction is a load
//   es_mem_req                 an SRAM request was issued, a response is owed
//   es_ld_op                   {ld_w, ld_h, ld_hu, ld_b, ld_bu}
//   es_except                  exception vector, carried to WB
//   data_sram_data_ok/_rdata   SRAM response handshake and read data
//   except_flush               WB exception / ertn flush
//   ws_allowin / ms_to_ws_valid  MEM->WB handshake
//   ms_pc, ms_final_result, ms_rf_we, ms_rf_waddr, ms_except  payload to WB
//   ms_rf_collect              {ld_pending, we, waddr, result} for ID
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        es_to_ms_valid,
    output logic        ms_allowin,
    input  logic [31:0] es_pc,
    input  logic [31:0] es_result,
    input  logic        es_rf_we,
    input  logic [4:0]  es_rf_waddr,
    input  logic        es_res_from_mem,
    input  logic        es_mem_req,
    input  logic [4:0]  es_ld_op,
    input  logic [15:0] es_except,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    input  logic        except_flush,
    input  logic        ws_allowin,
    output logic        ms_to_ws_valid,
    output logic [31:0] ms_pc,
    output logic [31:0] ms_final_result,
    output logic        ms_rf_we,
    output logic [4:0]  ms_rf_waddr,
    output logic [15:0] ms_except,
    output logic [38:0] ms_rf_collect
);

    // At most two responses can be orphaned at once (one in MEM, one in EX).
    localparam logic [CNT_W:0] CNT_MAX = (CNT_W + 1)'(2);

    logic             ms_valid_r;
    logic [31:0]      pc_r;
    logic [31:0]      result_r;
    logic             rf_we_r;
    logic [4:0]       rf_waddr_r;
    logic             res_from_mem_r;
    logic             mem_req_r;
    logic [4:0]       ld_op_r;
    logic [15:0]      except_r;
    logic             data_got_r;
    logic [31:0]      rdata_buf_r;
    logic [CNT_W-1:0] cnt_r;

    logic             resp_acc_s;
    logic             ready_go_s;
    logic             load_s;
    logic             orph_ms_s;
    logic             orph_es_s;
    logic             dec_s;
    logic [CNT_W:0]   inc_s;
    logic [CNT_W:0]   cnt_sum_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [31:0]      ld_data_s;
    logic [7:0]       byte_s;
    logic [15:0]      half_s;
    logic [31:0]      ext_s;
    logic [31:0]      final_s;
    logic             ld_pending_s;

    // Handshake: a response belongs to MEM only when no cancelled ones are ahead of it.
    always_comb begin
        resp_acc_s = data_sram_data_ok & (cnt_r == {CNT_W{1'b0}});
        ready_go_s = ~mem_req_r | data_got_r | resp_acc_s;
        ms_allowin = ~ms_valid_r | (ready_go_s & ws_allowin);
        ms_to_ws_valid = ms_valid_r & ready_go_s & ~except_flush;
        load_s = es_to_ms_valid & ms_allowin;
    end

    // Stage valid bit: flush kills the instruction, otherwise refill when allowed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid_r <= 1'b0;
        end else if (except_flush) begin
            ms_valid_r <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid_r <= es_to_ms_valid;
        end else begin
            ms_valid_r <= ms_valid_r;
        end
    end

    // Payload registers: load only on a real transfer so WB sees stable data while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r           <= 32'h0000_0000;
            result_r       <= 32'h0000_0000;
            rf_we_r        <= 1'b0;
            rf_waddr_r     <= 5'd0;
            res_from_mem_r <= 1'b0;
            mem_req_r      <= 1'b0;
            ld_op_r        <= 5'd0;
            except_r       <= 16'h0000;
        end else if (load_s) begin
            pc_r           <= es_pc;
            result_r       <= es_result;
            rf_we_r        <= es_rf_we;
            rf_waddr_r     <= es_rf_waddr;
            res_from_mem_r <= es_res_from_mem;
            mem_req_r      <= es_mem_req;
            ld_op_r        <= es_ld_op;
            except_r       <= es_except;
        end else begin
            pc_r           <= pc_r;
            result_r       <= result_r;
            rf_we_r        <= rf_we_r;
            rf_waddr_r     <= rf_waddr_r;
            res_from_mem_r <= res_from_mem_r;
            mem_req_r      <= mem_req_r;
            ld_op_r        <= ld_op_r;
            except_r       <= except_r;
        end
    end

    // Response capture: hold SRAM data while WB stalls so it is not lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_got_r  <= 1'b0;
            rdata_buf_r <= 32'h0000_0000;
        end else if (load_s | except_flush) begin
            data_got_r  <= 1'b0;
            rdata_buf_r <= rdata_buf_r;
        end else if (ms_valid_r & mem_req_r & ~data_got_r & resp_acc_s) begin
            data_got_r  <= 1'b1;
            rdata_buf_r <= data_sram_rdata;
        end else begin
            data_got_r  <= data_got_r;
            rdata_buf_r <= rdata_buf_r;
        end
    end

    // Cancel counter next value: orphaned responses on flush, minus one discarded response.
    always_comb begin
        orph_ms_s = ms_valid_r & mem_req_r & ~data_got_r & ~resp_acc_s;
        orph_es_s = es_to_ms_valid & es_mem_req;
        if (except_flush) begin
            inc_s = {{CNT_W{1'b0}}, orph_ms_s} + {{CNT_W{1'b0}}, orph_es_s};
        end else begin
            inc_s = {(CNT_W + 1){1'b0}};
        end
        dec_s = data_sram_data_ok & (cnt_r != {CNT_W{1'b0}});
        cnt_sum_s = {1'b0, cnt_r} + inc_s - {{CNT_W{1'b0}}, dec_s};
        if (cnt_sum_s > CNT_MAX) begin
            cnt_nxt_s = CNT_MAX[CNT_W-1:0];
        end else begin
            cnt_nxt_s = cnt_sum_s[CNT_W-1:0];
        end
    end

    // Cancel counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    // Load extension; same-cycle response bypasses the capture buffer.
    always_comb begin
        if (data_got_r) begin
            ld_data_s = rdata_buf_r;
        end else begin
            ld_data_s = data_sram_rdata;
        end
        case (result_r[1:0])
            2'd0:    byte_s = ld_data_s[7:0];
            2'd1:    byte_s = ld_data_s[15:8];
            2'd2:    byte_s = ld_data_s[23:16];
            2'd3:    byte_s = ld_data_s[31:24];
            default: byte_s = 8'h00;
        endcase
        if (result_r[1]) begin
            half_s = ld_data_s[31:16];
        end else begin
            half_s = ld_data_s[15:0];
        end
        case (ld_op_r)
            5'b10000: ext_s = ld_data_s;
            5'b01000: ext_s = {{16{half_s[15]}}, half_s};
            5'b00100: ext_s = {16'h0000, half_s};
            5'b00010: ext_s = {{24{byte_s[7]}}, byte_s};
            5'b00001: ext_s = {24'h000000, byte_s};
            default:  ext_s = ld_data_s;
        endcase
        if (res_from_mem_r) begin
            final_s = ext_s;
        end else begin
            final_s = result_r;
        end
        ld_pending_s = ms_valid_r & res_from_mem_r & ~ready_go_s;
    end

    // Forwarding bundle is zeroed when the stage is empty so ID never matches stale data.
    always_comb begin
        if (ms_valid_r) begin
            ms_rf_collect = {ld_pending_s, rf_we_r, rf_waddr_r, final_s};
        end else begin
            ms_rf_collect = {ld_pending_s, 38'd0};
        end
    end

    assign ms_pc           = pc_r;
    assign ms_final_result = final_s;
    assign ms_rf_we        = rf_we_r;
    assign ms_rf_waddr     = rf_waddr_r;
    assign ms_except       = except_r;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage -- directed self-checking bench for mem_stage. Expected WB
// transfers are queued when an instruction is issued and compared when MEM
// hands an instruction to WB; direct checks cover handshake and flush cases.
// -----------------------------------------------------------------------------
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        es_to_ms_valid;
    logic        ms_allowin;
    logic [31:0] es_pc;
    logic [31:0] es_result;
    logic        es_rf_we;
    logic [4:0]  es_rf_waddr;
    logic        es_res_from_mem;
    logic        es_mem_req;
    logic [4:0]  es_ld_op;
    logic [15:0] es_except;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        except_flush;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [31:0] ms_pc;
    logic [31:0] ms_final_result;
    logic        ms_rf_we;
    logic [4:0]  ms_rf_waddr;
    logic [15:0] ms_except;
    logic [38:0] ms_rf_collect;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] res;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    mem_stage #(.CNT_W(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .es_to_ms_valid    (es_to_ms_valid),
        .ms_allowin        (ms_allowin),
        .es_pc             (es_pc),
        .es_result         (es_result),
        .es_rf_we          (es_rf_we),
        .es_rf_waddr       (es_rf_waddr),
        .es_res_from_mem   (es_res_from_mem),
        .es_mem_req        (es_mem_req),
        .es_ld_op          (es_ld_op),
        .es_except         (es_except),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .except_flush      (except_flush),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_pc             (ms_pc),
        .ms_final_result   (ms_final_result),
        .ms_rf_we          (ms_rf_we),
        .ms_rf_waddr       (ms_rf_waddr),
        .ms_except         (ms_except),
        .ms_rf_collect     (ms_rf_collect)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] wa,
                         input logic rfm, input logic mreq, input logic [4:0] op);
        es_to_ms_valid  = 1'b1;
        es_pc           = pc;
        es_result       = res;
        es_rf_we        = 1'b1;
        es_rf_waddr     = wa;
        es_res_from_mem = rfm;
        es_mem_req      = mreq;
        es_ld_op        = op;
        es_except       = 16'h0000;
    endtask

    // Scoreboard: every WB transfer must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && ms_to_ws_valid && ws_allowin) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_pc", {32'h0, ms_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_pc", {32'h0, ms_pc}, {32'h0, e.pc});
                chk("sb_result", {32'h0, ms_final_result}, {32'h0, e.res});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        es_to_ms_valid = 1'b0;
        es_pc = 32'h0; es_result = 32'h0; es_rf_we = 1'b0; es_rf_waddr = 5'd0;
        es_res_from_mem = 1'b0; es_mem_req = 1'b0; es_ld_op = 5'd0; es_except = 16'h0;
        data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
        except_flush = 1'b0; ws_allowin = 1'b1;

        // Reset state
        tick(); tick();
        @(negedge clk);
        chk("rst_allowin", {63'h0, ms_allowin}, 64'd1);
        chk("rst_to_ws", {63'h0, ms_to_ws_valid}, 64'd0);
        chk("rst_collect", {25'h0, ms_rf_collect}, 64'd0);
        chk("rst_pc", {32'h0, ms_pc}, 64'd0);
        tick();
        reset = 1'b0;

        // ALU op, then back-to-back ALU ops at full rate
        issue(32'h100, 32'h1234, 5'd5, 1'b0, 1'b0, 5'd0);
        sb_q.push_back('{pc: 32'h100, res: 32'h1234});
        @(negedge clk);
        chk("alu_allowin", {63'h0, ms_allowin}, 64'd1);
        tick();
        es_to_ms_valid = 1'b0;
        @(negedge clk);
        chk("alu_to_ws", {63'h0, ms_to_ws_valid}, 64'd1);
        chk("alu_collect", {25'h0, ms_rf_collect}, {25'h0, 1'b0, 1'b1, 5'd5, 32'h1234});
        tick();
        for (int i = 0; i < 4; i++) begin
            issue(32'h200 + 32'(4 * i), 32'hA000 + 32'(i), 5'(i + 1), 1'b0, 1'b0, 5'd0);
            sb_q.push_back('{pc: 32'h200 + 32'(4 * i), res: 32'hA000 + 32'(i)});
            @(negedge clk);
            chk("b2b_allowin", {63'h0, ms_allowin}, 64'd1);
            tick();
        end
        es_to_ms_valid = 1'b0;
        @(negedge clk);
        chk("b2b_last_to_ws", {63'h0, ms_to_ws_valid}, 64'd1);
        tick();
        @(negedge clk);
        chk("b2b_drained", {63'h0, ms_to_ws_valid}, 64'd0);

        // ld_b at 0x1003, data two cycles later
        issue(32'h300, 32'h1003, 5'd7, 1'b1, 1'b1, 5'b00010);
        sb_q.push_back('{pc: 32'h300, res: 32'hFFFF_FF80});
        tick();
        es_to_ms_valid = 1'b0;
        @(negedge clk);
        chk("ldb_wait_to_ws", {63'h0, ms_to_ws_valid}, 64'd0);
        chk("ldb_ld_pending", {63'h0, ms_rf_collect[38]}, 64'd1);
        tick();
        tick();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80AA_BBCC;
        @(negedge clk);
        chk("ldb_to_ws", {63'h0, ms_to_ws_valid}, 64'd1);
        chk("ldb_result", {32'h0, ms_final_result}, 64'h0000_0000_FFFF_FF80);
        tick();
        data_sram_data_ok = 1'b0;
        @(negedge clk);
        chk("ldb_one_cycle", {63'h0, ms_to_ws_valid}, 64'd0);

        // ld_hu at 0x2002 with WB stalled when data arrives
        ws_allowin = 1'b0;
        issue(32'h400, 32'h2002, 5'd8, 1'b1, 1'b1, 5'b00100);
        sb_q.push_back('{pc: 32'h400, res: 32'h0000_8001});
        tick();
        es_to_ms_valid = 1'b0;
        tick();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8001_1234;
        @(negedge clk);
        chk("ldhu_stall_allowin0", {63'h0, ms_allowin}, 64'd0);
        tick();
        data_sram_data_ok = 1'b0; data_sram_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("ldhu_stall_allowin1", {63'h0, ms_allowin}, 64'd0);
        chk("ldhu_buffered", {32'h0, ms_final_result}, 64'h0000_0000_0000_8001);
        tick();
        @(negedge clk);
        chk("ldhu_stall_allowin2", {63'h0, ms_allowin}, 64'd0);
        tick();
        ws_allowin = 1'b1;
        @(negedge clk);
        chk("ldhu_release_to_ws", {63'h0, ms_to_ws_valid}, 64'd1);
        chk("ldhu_release_allowin", {63'h0, ms_allowin}, 64'd1);
        tick();
        @(negedge clk);
        chk("ldhu_drained", {63'h0, ms_to_ws_valid}, 64'd0);

        // Flush a waiting load, stale response discarded, next load completes
        issue(32'h500, 32'h3000, 5'd9, 1'b1, 1'b1, 5'b10000);
        tick();
        es_to_ms_valid = 1'b0;
        tick();
        except_flush = 1'b1;
        @(negedge clk);
        chk("flush1_to_ws", {63'h0, ms_to_ws_valid}, 64'd0);
        tick();
        except_flush = 1'b0;
        @(negedge clk);
        chk("flush1_collect", {25'h0, ms_rf_collect}, 64'd0);
        chk("flush1_allowin", {63'h0, ms_allowin}, 64'd1);
        issue(32'h600, 32'h3004, 5'd10, 1'b1, 1'b1, 5'b10000);
        sb_q.push_back('{pc: 32'h600, res: 32'h1122_3344});
        tick();
        es_to_ms_valid = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("flush1_stale_dropped", {63'h0, ms_to_ws_valid}, 64'd0);
        tick();
        data_sram_data_ok = 1'b0;
        @(negedge clk);
        chk("flush1_still_wait", {63'h0, ms_to_ws_valid}, 64'd0);
        tick();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1122_3344;
        @(negedge clk);
        chk("flush1_own_data", {63'h0, ms_to_ws_valid}, 64'd1);
        tick();
        data_sram_data_ok = 1'b0;

        // Flush with a waiting load and a new request from EX: two responses dropped
        issue(32'h700, 32'h3008, 5'd11, 1'b1, 1'b1, 5'b10000);
        tick();
        issue(32'h704, 32'h300C, 5'd12, 1'b1, 1'b1, 5'b10000);
        except_flush = 1'b1;
        @(negedge clk);
        chk("flush2_to_ws", {63'h0, ms_to_ws_valid}, 64'd0);
        tick();
        es_to_ms_valid = 1'b0; except_flush = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0BAD_0001;
        @(negedge clk);
        chk("flush2_drop1", {63'h0, ms_to_ws_valid}, 64'd0);
        tick();
        data_sram_data_ok = 1'b0;
        tick();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0BAD_0002;
        @(negedge clk);
        chk("flush2_drop2", {63'h0, ms_to_ws_valid}, 64'd0);
        chk("flush2_collect", {25'h0, ms_rf_collect}, 64'd0);
        tick();
        data_sram_data_ok = 1'b0;
        issue(32'h800, 32'h3010, 5'd13, 1'b1, 1'b1, 5'b10000);
        sb_q.push_back('{pc: 32'h800, res: 32'hCAFE_F00D});
        tick();
        es_to_ms_valid = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("flush2_recovered", {63'h0, ms_to_ws_valid}, 64'd1);
        tick();
        data_sram_data_ok = 1'b0;

        // Reset while a cancelled response is owed zeroes the counter
        issue(32'h900, 32'h3014, 5'd14, 1'b1, 1'b1, 5'b10000);
        tick();
        es_to_ms_valid = 1'b0;
        except_flush = 1'b1;
        tick();
        except_flush = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_allowin", {63'h0, ms_allowin}, 64'd1);
        chk("midrst_collect", {25'h0, ms_rf_collect}, 64'd0);
        chk("midrst_pc", {32'h0, ms_pc}, 64'd0);
        tick();
        reset = 1'b0;
        issue(32'hA00, 32'h4002, 5'd15, 1'b1, 1'b1, 5'b01000);
        sb_q.push_back('{pc: 32'hA00, res: 32'hFFFF_9ABC});
        tick();
        es_to_ms_valid = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h9ABC_1234;
        @(negedge clk);
        chk("ldh_after_rst", {63'h0, ms_to_ws_valid}, 64'd1);
        tick();
        data_sram_data_ok = 1'b0;
        issue(32'hB00, 32'h4001, 5'd16, 1'b1, 1'b1, 5'b00001);
        sb_q.push_back('{pc: 32'hB00, res: 32'h0000_0084});
        tick();
        es_to_ms_valid = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h12AB_8456;
        @(negedge clk);
        chk("ldbu_to_ws", {63'h0, ms_to_ws_valid}, 64'd1);
        tick();
        data_sram_data_ok = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
